// File: rtl/jtag_host_scan.sv
// JTAG initiator: runs one TLR, IR-scan or DR-scan command as TCK/TMS/TDI
// waveforms and returns the TDO bits captured during Shift-xR.
module jtag_host_scan #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_tlr,
  input  logic        cmd_ir,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  output logic [31:0] rsp_tdo,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    PRE,
    SHIFT,
    POST,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             ir_q;
  logic [IDX_W-1:0] len_q;
  logic [31:0]      data_q;

  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] pre_last;

  // Next pulse index and the index of the last pulse of the PRE sequence
  always_comb begin
    idx_inc  = idx + IDX_W'(1);
    pre_last = ir_q ? IDX_W'(3) : IDX_W'(2);
  end

  // Sequencer: prescaler, TMS plan per state, TDO capture and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TLR_SEQ;
      cnt       <= '0;
      idx       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tdo   <= '0;
      ir_q      <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          tck <= 1'b0;
          tms <= 1'b0;
          tdi <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            // Both PRE and TLR sequences start with TMS=1
            cmd_ready <= 1'b0;
            rsp_tdo   <= '0;
            ir_q      <= cmd_ir;
            len_q     <= cmd_len;
            data_q    <= cmd_tdi;
            cnt       <= '0;
            idx       <= '0;
            tms       <= 1'b1;
            state     <= cmd_tlr ? TLR_SEQ : PRE;
          end
        end

        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            tck <= ~tck;
            if (!tck) begin
              // TCK rising edge: TAP samples TMS/TDI, host samples TDO
              if (state == SHIFT) begin
                rsp_tdo[idx] <= tdo;
              end
            end else begin
              // TCK falling edge: present TMS/TDI for the next pulse
              case (state)
                TLR_SEQ: begin
                  if (idx == IDX_W'(5)) begin
                    idx       <= '0;
                    tms       <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                  end else begin
                    idx <= idx_inc;
                    tms <= (idx != IDX_W'(4));
                  end
                end
                PRE: begin
                  if (idx == pre_last) begin
                    idx   <= '0;
                    tms   <= (len_q == '0);
                    tdi   <= data_q[0];
                    state <= SHIFT;
                  end else begin
                    idx <= idx_inc;
                    tms <= ir_q && (idx == '0);
                  end
                end
                SHIFT: begin
                  if (idx == len_q) begin
                    idx   <= '0;
                    tms   <= 1'b1;
                    tdi   <= 1'b0;
                    state <= POST;
                  end else begin
                    idx <= idx_inc;
                    tms <= (idx_inc == len_q);
                    tdi <= data_q[idx_inc];
                  end
                end
                POST: begin
                  tms <= 1'b0;
                  if (idx == '0) begin
                    idx <= IDX_W'(1);
                  end else begin
                    idx       <= '0;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                  end
                end
                default: begin
                  state <= TLR_SEQ;
                end
              endcase
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
